// File: rtl/add_serial_ctrl.sv
// ============================================================================
// add_serial_ctrl : bit-serial WIDTH-bit adder built around a single add1bit.
// Optional ADD_SERIAL_SUB_EN adds a 'sub' input for a - b (two's complement).
// Rev 1.0
// ============================================================================
`default_nettype none

module add1bit (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic sum_o,
   output logic c_o
);
   assign sum_o = a_i ^ b_i ^ c_i;
   assign c_o   = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module add_serial_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
`ifdef ADD_SERIAL_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             c_out_q, c_out_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             w_fa_sum;
   logic             w_fa_c;
   logic [WIDTH-1:0] w_sum_shift;
   logic [WIDTH-1:0] w_b_load;
   logic             w_c_load;

   add1bit u_fa (
      .a_i   (a_sh_q[0]),
      .b_i   (b_sh_q[0]),
      .c_i   (carry_q),
      .sum_o (w_fa_sum),
      .c_o   (w_fa_c)
   );

   // New sum bits enter at the MSB so bit i settles in position i after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_shift_w1
         assign w_sum_shift = w_fa_sum;
      end else begin : g_shift_wn
         assign w_sum_shift = {w_fa_sum, sum_sh_q[WIDTH-1:1]};
      end
   endgenerate

`ifdef ADD_SERIAL_SUB_EN
   assign w_b_load = sub ? ~b : b;
   assign w_c_load = sub ? 1'b1 : c_in;
`else
   assign w_b_load = b;
   assign w_c_load = c_in;
`endif

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      c_out_d  = c_out_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = w_b_load;
               carry_d = w_c_load;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            sum_sh_d = w_sum_shift;
            carry_d  = w_fa_c;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == C_LAST) begin
               state_d = DONE;
               sum_d   = w_sum_shift;
               c_out_d = w_fa_c;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         c_out_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         c_out_q  <= c_out_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy  = (state_q == RUN);
   assign done  = (state_q == DONE);
   assign sum   = sum_q;
   assign c_out = c_out_q;

endmodule

`default_nettype wire

// File: tb/tb_add_serial_ctrl.sv
// ============================================================================
// tb_add_serial_ctrl : directed vectors for WIDTH=8 and WIDTH=1 instances.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_add_serial_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       cin8 = 1'b0;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;
`ifdef ADD_SERIAL_SUB_EN
   logic       sub8 = 1'b0;
`endif

   logic       start1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       cin1 = 1'b0;
   logic       busy1, done1, cout1;
   logic [0:0] sum1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   add_serial_ctrl #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .c_in  (cin8),
`ifdef ADD_SERIAL_SUB_EN
      .sub   (sub8),
`endif
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .c_out (cout8)
   );

   add_serial_ctrl #(.WIDTH(1)) u_dut1 (
      .clk   (clk),
      .rst   (rst),
      .start (start1),
      .a     (a1),
      .b     (b1),
      .c_in  (cin1),
`ifdef ADD_SERIAL_SUB_EN
      .sub   (1'b0),
`endif
      .busy  (busy1),
      .done  (done1),
      .sum   (sum1),
      .c_out (cout1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Full addition on the 8-bit DUT; operands are scrambled after the start
   // edge, and the previous result must hold throughout RUN.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, input logic [7:0] exp_sum, input logic exp_c,
                       input logic [7:0] hold_sum, input logic hold_c);
      @(negedge clk);
      start8 = 1'b1; a8 = a; b8 = b; cin8 = cin;
`ifdef ADD_SERIAL_SUB_EN
      sub8 = sub;
`else
      if (sub) $display("FAIL run8_sub: sub requested without feature, got 1 expected 0");
`endif
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) begin
            start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~cin;
         end
         check($sformatf("busy8[%0d]", i), busy8, 1);
         check($sformatf("done8_run[%0d]", i), done8, 0);
         check($sformatf("hold_sum8[%0d]", i), sum8, hold_sum);
         check($sformatf("hold_c8[%0d]", i), cout8, hold_c);
      end
      @(negedge clk);
      check("done8", done8, 1);
      check("busy8_done", busy8, 0);
      check("sum8", sum8, exp_sum);
      check("cout8", cout8, exp_c);
      @(negedge clk);
      check("done8_pulse_end", done8, 0);
      check("sum8_after", sum8, exp_sum);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int ndone;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy8", busy8, 0);
      check("rst_done8", done8, 0);
      check("rst_sum8", sum8, 0);
      check("rst_cout8", cout8, 0);
      check("rst_busy1", busy1, 0);
      check("rst_sum1", sum1, 0);
      rst = 1'b0;

      run8(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 8'h00, 1'b0);
      run8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 8'h8D, 1'b0);
      run8(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b1);
      run8(8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 8'hFF, 1'b1);

      // Second start during RUN must be ignored.
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         start8 = (i == 2);
         if (i == 2) begin a8 = 8'hAA; b8 = 8'hAA; end
         check($sformatf("busy8_restart[%0d]", i), busy8, 1);
      end
      start8 = 1'b0;
      @(negedge clk);
      check("done8_restart", done8, 1);
      check("sum8_restart", sum8, 8'h46);
      check("cout8_restart", cout8, 0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done8) ndone++;
      end
      check("restart_single_done", ndone, 0);
      check("restart_idle", busy8, 0);

      // Reset in the middle of RUN aborts the operation.
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start8 = 1'b0;
      end
      check("busy8_pre_rst", busy8, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy8", busy8, 0);
      check("midrst_done8", done8, 0);
      check("midrst_sum8", sum8, 0);
      check("midrst_cout8", cout8, 0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done8 || busy8) ndone++;
      end
      check("midrst_no_done", ndone, 0);
      run8(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 8'h00, 1'b0);

`ifdef ADD_SERIAL_SUB_EN
      run8(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 8'h03, 1'b0);
      run8(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h0F, 1'b1);
      run8(8'h20, 8'h05, 1'b1, 1'b0, 8'h26, 1'b0, 8'hFF, 1'b0);
`endif

      // WIDTH=1: one RUN cycle, done two cycles after the start edge.
      @(negedge clk);
      start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
      check("busy1", busy1, 1);
      check("done1_run", done1, 0);
      @(negedge clk);
      check("done1", done1, 1);
      check("busy1_done", busy1, 0);
      check("sum1", sum1, 1);
      check("cout1", cout1, 1);
      @(negedge clk);
      check("done1_pulse_end", done1, 0);

      @(negedge clk);
      start1 = 1'b1; a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
      @(negedge clk);
      start1 = 1'b0;
      check("sum1_hold", sum1, 1);
      @(negedge clk);
      check("sum1_b", sum1, 1);
      check("cout1_b", cout1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
